// File: rtl/hw24.sv
// Single-clock circular FIFO with registered read data and occupancy-based
// almost-full / almost-empty flags.
module hw24 #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic             rd,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [PTR_W-1:0] wrptr,
    output logic [PTR_W-1:0] rdptr,
    output logic             almostfull,
    output logic             almostempty
);

    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] EMPTY_CNT = CNT_W'(0);
    localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(AE_LEVEL);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wrptr_q, wrptr_d;
    logic [PTR_W-1:0] rdptr_q, rdptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] dout_q,  dout_d;

    logic full_s;
    logic empty_s;
    logic wr_acc_s;
    logic rd_acc_s;

    // Acceptance: a write into a full buffer is allowed only when a read frees the slot.
    always_comb begin
        full_s   = (count_q == FULL_CNT);
        empty_s  = (count_q == EMPTY_CNT);
        rd_acc_s = rd && !empty_s;
        wr_acc_s = wr && (!full_s || rd);
    end

    // Next-state for pointers, occupancy and read data.
    always_comb begin
        wrptr_d = wrptr_q;
        rdptr_d = rdptr_q;
        dout_d  = dout_q;
        count_d = count_q;

        if (wr_acc_s) begin
            wrptr_d = wrptr_q + PTR_W'(1);
        end else begin
            wrptr_d = wrptr_q;
        end

        if (rd_acc_s) begin
            rdptr_d = rdptr_q + PTR_W'(1);
            dout_d  = mem_q[rdptr_q];
        end else begin
            rdptr_d = rdptr_q;
            dout_d  = dout_q;
        end

        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            2'b11:   count_d = count_q;
            2'b00:   count_d = count_q;
            default: count_d = count_q;
        endcase
    end

    // Control state with synchronous reset; reset wins over any request.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrptr_q <= {PTR_W{1'b0}};
            rdptr_q <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
            dout_q  <= {WIDTH{1'b0}};
        end else begin
            wrptr_q <= wrptr_d;
            rdptr_q <= rdptr_d;
            count_q <= count_d;
            dout_q  <= dout_d;
        end
    end

    // Storage array; contents survive reset, only the write is suppressed.
    always_ff @(posedge clk) begin
        if (wr_acc_s && !rst) begin
            mem_q[wrptr_q] <= din;
        end
    end

    // Flags follow the registered occupancy.
    always_comb begin
        almostfull  = (count_q >= AF_CNT);
        almostempty = (count_q <= AE_CNT);
    end

    assign dout  = dout_q;
    assign wrptr = wrptr_q;
    assign rdptr = rdptr_q;

endmodule

// File: tb/tb_hw24.sv
// Self-checking bench for hw24: directed scenarios plus random traffic,
// compared against a queue-based reference model.
module tb_hw24;

    logic       clk;
    logic       rst;
    logic       wr;
    logic       rd;
    logic [7:0] din;
    logic [7:0] dout;
    logic [3:0] wrptr;
    logic [3:0] rdptr;
    logic       almostfull;
    logic       almostempty;

    int checks = 0;
    int errors = 0;

    // Reference model: contents in a queue, pointers from accepted totals.
    logic [7:0] q[$];
    logic [7:0] exp_dout;
    int         wr_total;
    int         rd_total;

    hw24 dut (
        .clk         (clk),
        .rst         (rst),
        .wr          (wr),
        .rd          (rd),
        .din         (din),
        .dout        (dout),
        .wrptr       (wrptr),
        .rdptr       (rdptr),
        .almostfull  (almostfull),
        .almostempty (almostempty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic w, input logic r, input logic [7:0] d, input logic rs);
        if (rs) begin
            q.delete();
            exp_dout = 8'd0;
            wr_total = 0;
            rd_total = 0;
        end else begin
            if (r && q.size() > 0) begin
                exp_dout = q.pop_front();
                rd_total++;
            end
            if (w && q.size() < 16) begin
                q.push_back(d);
                wr_total++;
            end
        end
    endtask

    task automatic step(input logic w, input logic r, input logic [7:0] d, input logic rs);
        @(negedge clk);
        wr  = w;
        rd  = r;
        din = d;
        rst = rs;
        @(posedge clk);
        model_update(w, r, d, rs);
        #1;
        check("dout",        32'(dout),        32'(exp_dout));
        check("wrptr",       32'(wrptr),       32'(wr_total % 16));
        check("rdptr",       32'(rdptr),       32'(rd_total % 16));
        check("almostfull",  32'(almostfull),  32'(q.size() >= 14));
        check("almostempty", 32'(almostempty), 32'(q.size() <= 2));
    endtask

    initial begin
        int n_wr;
        wr = 1'b0; rd = 1'b0; din = 8'd0; rst = 1'b1;
        exp_dout = 8'd0; wr_total = 0; rd_total = 0;

        // Reset then idle
        step(1'b0, 1'b0, 8'd0, 1'b1);
        step(1'b0, 1'b0, 8'd0, 1'b0);
        check("rst_wrptr", 32'(wrptr), 32'd0);
        check("rst_dout",  32'(dout),  32'd0);
        check("rst_ae",    32'(almostempty), 32'd1);
        check("rst_af",    32'(almostfull),  32'd0);

        // 12 spaced writes, then 12 reads
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 8'($urandom), 1'b0);
            if (i == 1) check("ae_after_2nd", 32'(almostempty), 32'd1);
            if (i == 2) check("ae_after_3rd", 32'(almostempty), 32'd0);
            for (int k = 0; k < int'($urandom_range(15, 4)); k++)
                step(1'b0, 1'b0, 8'($urandom), 1'b0);
        end
        check("wrptr_12", 32'(wrptr), 32'd12);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 8'd0, 1'b0);
            if (i == 8) check("ae_after_9th_rd",  32'(almostempty), 32'd0);
            if (i == 9) check("ae_after_10th_rd", 32'(almostempty), 32'd1);
        end
        check("rdptr_12", 32'(rdptr), 32'd12);

        // Fill to full, overflow attempt, drain
        step(1'b0, 1'b0, 8'd0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 8'($urandom), 1'b0);
            if (i == 12) check("af_after_13th", 32'(almostfull), 32'd0);
            if (i == 13) check("af_after_14th", 32'(almostfull), 32'd1);
        end
        step(1'b1, 1'b0, 8'hA5, 1'b0);
        check("overflow_wrptr", 32'(wrptr), 32'd0);
        // Simultaneous wr/rd while full keeps it full
        step(1'b1, 1'b1, 8'h3C, 1'b0);
        check("full_wr_rd_af", 32'(almostfull), 32'd1);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'd0, 1'b0);
        check("drained_ae", 32'(almostempty), 32'd1);

        // Empty corner cases
        step(1'b0, 1'b1, 8'd0, 1'b0);
        step(1'b1, 1'b1, 8'h5A, 1'b0);
        step(1'b0, 1'b1, 8'd0, 1'b0);
        check("empty_wr_rd_data", 32'(dout), 32'h5A);

        // Wrap-around: 20 accepted writes interleaved with reads
        step(1'b0, 1'b0, 8'd0, 1'b1);
        n_wr = 0;
        while (n_wr < 20) begin
            logic w;
            w = ($urandom_range(2, 0) != 0);
            step(w, $urandom_range(1, 0) == 1, 8'($urandom), 1'b0);
            if (w) n_wr++;
        end
        while (q.size() > 0) step(1'b0, 1'b1, 8'd0, 1'b0);

        // Reset mid-operation with a pending write
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0);
        step(1'b0, 1'b1, 8'd0, 1'b0);
        step(1'b1, 1'b0, 8'h77, 1'b1);
        check("midrst_wrptr", 32'(wrptr), 32'd0);
        check("midrst_dout",  32'(dout),  32'd0);
        check("midrst_ae",    32'(almostempty), 32'd1);
        step(1'b0, 1'b1, 8'd0, 1'b0);
        check("midrst_empty_read", 32'(dout), 32'd0);

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(99, 0) < 55, $urandom_range(99, 0) < 45,
                 8'($urandom), $urandom_range(99, 0) < 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
